// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shift engine. Pops words from a TX buffer, shifts them
// out MSB-first on MOSI while sampling MISO, and pushes each received word
// into an RX buffer. Chip select stays low across back-to-back words while
// TX data keeps coming. Assumes DWIDTH >= 2 and CLK_DIV >= 1.
module spi_master_shifter #(
  parameter int DWIDTH  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              tx_empty,
  output logic              tx_ren,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              rx_full,
  output logic              rx_wen,
  output logic [DWIDTH-1:0] rx_data,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_rx_ovf
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BITW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(DWIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_DONE, S_HOLD
  } state_t;

  state_t            state_q;
  logic [DIVW-1:0]   div_q;     // SCLK half-period divider, also times HOLD
  logic [BITW-1:0]   bit_q;
  logic [DWIDTH-1:0] tx_sh_q;
  logic [DWIDTH-1:0] rx_sh_q;
  logic [DWIDTH-1:0] rx_data_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              cs_n_q;

  logic div_tc;
  logic start_ok;

  assign div_tc   = (div_q == DIV_LAST);
  assign start_ok = i_en && !tx_empty;

  // Buffer strobes and the overflow pulse decode the registered state; all
  // three are forced low while reset is asserted.
  assign tx_ren   = i_rst_n && (state_q == S_FETCH) && !tx_empty;
  assign rx_wen   = i_rst_n && (state_q == S_DONE) && !rx_full;
  assign o_rx_ovf = i_rst_n && (state_q == S_DONE) && rx_full;
  assign o_busy   = (state_q != S_IDLE);
  assign o_sclk   = sclk_q;
  assign o_mosi   = mosi_q;
  assign o_cs_n   = cs_n_q;
  assign rx_data  = rx_data_q;

  // Transfer FSM: word fetch/load, SCLK generation, shifting, and CS hold-off.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cs_n_q <= 1'b1;
          sclk_q <= 1'b0;
          if (start_ok) state_q <= S_FETCH;
        end
        // tx_ren is high this cycle; the buffer presents the word in LOAD.
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          tx_sh_q <= tx_data;
          mosi_q  <= tx_data[DWIDTH-1];
          cs_n_q  <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
          rx_sh_q <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_tc) begin
            div_q <= '0;
            if (!sclk_q) begin
              // Rising edge: sample MISO.
              sclk_q  <= 1'b1;
              rx_sh_q <= {rx_sh_q[DWIDTH-2:0], i_miso};
            end else begin
              // Falling edge: either finish the word or present the next bit.
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                rx_data_q <= rx_sh_q;
                state_q   <= S_DONE;
              end else begin
                tx_sh_q <= tx_sh_q << 1;
                mosi_q  <= tx_sh_q[DWIDTH-2];
                bit_q   <= bit_q + 1'b1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_DONE: begin
          // Chain straight into the next word with CS still low if possible.
          if (start_ok) begin
            state_q <= S_FETCH;
          end else begin
            div_q   <= '0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (div_tc) begin
            cs_n_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter (DWIDTH=8, CLK_DIV=2). A word-offset model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_spi_master_shifter;

  localparam int DW       = 8;
  localparam int CD       = 2;
  localparam int SH       = DW * 2 * CD;
  localparam int DONE_OFF = 2 + SH;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_en = 1'b0;
  logic          tx_empty;
  logic          tx_ren;
  logic [DW-1:0] tx_data = '0;
  logic          rx_full = 1'b0;
  logic          rx_wen;
  logic [DW-1:0] rx_data;
  logic          o_sclk, o_mosi, i_miso, o_cs_n, o_busy, o_rx_ovf;

  int nchk = 0;
  int nerr = 0;

  // TX buffer: array with read/write pointers, data one cycle after tx_ren.
  logic [DW-1:0] txmem [0:63];
  int wptr = 0;
  int rptr = 0;
  assign tx_empty = (wptr == rptr);
  always @(posedge i_clk) begin
    if (tx_ren) begin
      tx_data <= txmem[rptr];
      rptr    <= rptr + 1;
    end
  end

  // MISO either loops back MOSI or follows a bench-driven pattern.
  logic          loop = 1'b1;
  logic [DW-1:0] pat = '0;
  logic          miso_r = 1'b0;
  assign i_miso = loop ? o_mosi : miso_r;

  always #5 i_clk = ~i_clk;

  spi_master_shifter #(.DWIDTH(DW), .CLK_DIV(CD)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .tx_empty(tx_empty), .tx_ren(tx_ren), .tx_data(tx_data),
    .rx_full(rx_full), .rx_wen(rx_wen), .rx_data(rx_data),
    .o_sclk(o_sclk), .o_mosi(o_mosi), .i_miso(i_miso),
    .o_cs_n(o_cs_n), .o_busy(o_busy), .o_rx_ovf(o_rx_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Monitor counters (written only by the compare process).
  int rise_cnt = 0, cslow_cnt = 0, ren_cnt = 0, wen_cnt = 0, ovf_cnt = 0, mosi1_cnt = 0;
  logic [DW-1:0] rxlog [$];

  // Model state: m_off = cycles since FETCH of the current word (-1 = none),
  // m_hold = remaining HOLD cycles.
  int            m_off = -1;
  int            m_hold = 0;
  logic          cs_e = 1'b1;
  logic          mosi_e = 1'b0;
  logic [DW-1:0] m_word = '0;
  logic [DW-1:0] m_rxexp = '0;
  bit            mvalid = 1'b0;

  initial begin : cmp
    int k, e_sclk, e_ren, e_wen, e_ovf, e_busy;
    logic sclk_prev;
    sclk_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        chk("rst_tx_ren", tx_ren, 0);
        chk("rst_rx_wen", rx_wen, 0);
        m_off = -1; m_hold = 0; cs_e = 1'b1; mosi_e = 1'b0;
        mvalid = 1'b1; sclk_prev = 1'b0;
      end else if (mvalid) begin
        e_sclk = 0; e_ren = 0; e_wen = 0; e_ovf = 0; e_busy = 1;
        if (m_hold == 0 && m_off < 0) e_busy = 0;
        else if (m_off == 0) e_ren = 1;
        else if (m_off >= 2 && m_off < DONE_OFF) begin
          k = m_off - 2;
          e_sclk = (k / CD) % 2;
          mosi_e = m_word[DW-1-k/(2*CD)];
          cs_e = 1'b0;
        end else if (m_off == DONE_OFF) begin
          e_wen = !rx_full;
          e_ovf = rx_full;
        end
        chk("sclk", o_sclk, e_sclk);
        chk("cs_n", o_cs_n, cs_e);
        chk("mosi", o_mosi, mosi_e);
        chk("busy", o_busy, e_busy);
        chk("tx_ren", tx_ren, e_ren);
        chk("rx_wen", rx_wen, e_wen);
        chk("rx_ovf", o_rx_ovf, e_ovf);
        if (e_wen != 0) chk("rx_data", rx_data, m_rxexp);

        if (o_sclk && !sclk_prev) rise_cnt++;
        sclk_prev = o_sclk;
        if (!o_cs_n) cslow_cnt++;
        if (!o_cs_n && o_mosi) mosi1_cnt++;
        if (tx_ren) ren_cnt++;
        if (o_rx_ovf) ovf_cnt++;
        if (rx_wen) begin wen_cnt++; rxlog.push_back(rx_data); end

        if (m_hold > 0) begin
          m_hold--;
          if (m_hold == 0) cs_e = 1'b1;
        end else if (m_off < 0) begin
          if (i_en && !tx_empty) m_off = 0;
        end else if (m_off == 0) begin
          m_word  = txmem[rptr];
          m_rxexp = loop ? m_word : pat;
          m_off   = 1;
        end else if (m_off == DONE_OFF) begin
          if (i_en && !tx_empty) m_off = 0;
          else begin m_off = -1; m_hold = CD; end
        end else begin
          m_off++;
        end
      end
    end
  end

  int b_rise, b_cslow, b_ren, b_wen, b_ovf, b_mosi1, b_rx;

  task automatic snap();
    b_rise = rise_cnt; b_cslow = cslow_cnt; b_ren = ren_cnt;
    b_wen = wen_cnt; b_ovf = ovf_cnt; b_mosi1 = mosi1_cnt; b_rx = rxlog.size();
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    txmem[wptr] = b;
    wptr++;
  endtask

  function automatic logic [31:0] rxw(input int i);
    if (i < rxlog.size()) return {24'h0, rxlog[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge i_clk);
    while ((o_busy || (i_en && !tx_empty)) && n < 4000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 4000) tmo(nm);
    step();
  endtask

  task automatic wait_rises(input int t, input string nm);
    int n;
    n = 0;
    while ((rise_cnt - b_rise) < t && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 2000) tmo(nm);
  endtask

  task automatic wait_fall(input string nm);
    int n;
    logic p;
    n = 0;
    p = o_sclk;
    step();
    while (!(p && !o_sclk) && n < 400) begin
      p = o_sclk;
      step();
      n++;
    end
    if (n >= 400) tmo(nm);
  endtask

  initial begin : stim
    repeat (3) step();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("reset_cs_n", o_cs_n, 1);
    chk("reset_sclk", o_sclk, 0);
    chk("reset_mosi", o_mosi, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_rx_data", rx_data, 0);

    // Single word 0xA5, loopback.
    step();
    snap();
    push(8'hA5);
    i_en = 1'b1;
    wait_idle("t1_idle");
    chk("t1_rises", rise_cnt - b_rise, 8);
    chk("t1_cs_low_cycles", cslow_cnt - b_cslow, 35);
    chk("t1_ren", ren_cnt - b_ren, 1);
    chk("t1_wen", wen_cnt - b_wen, 1);
    chk("t1_rx0", rxw(b_rx), 32'hA5);
    chk("t1_busy_end", o_busy, 0);

    // Three-word burst with CS held low.
    snap();
    push(8'h01); push(8'h80); push(8'hFF);
    wait_idle("t2_idle");
    chk("t2_rises", rise_cnt - b_rise, 24);
    chk("t2_cs_low_cycles", cslow_cnt - b_cslow, 105);
    chk("t2_wen", wen_cnt - b_wen, 3);
    chk("t2_rx0", rxw(b_rx), 32'h01);
    chk("t2_rx1", rxw(b_rx + 1), 32'h80);
    chk("t2_rx2", rxw(b_rx + 2), 32'hFF);

    // MISO pattern 0x3C changed on falling edges, TX = 0x00.
    snap();
    loop = 1'b0;
    pat = 8'h3C;
    miso_r = pat[DW-1];
    push(8'h00);
    for (int b = DW - 2; b >= 0; b--) begin
      wait_fall("t3_fall");
      miso_r = pat[b];
    end
    wait_idle("t3_idle");
    loop = 1'b1;
    chk("t3_rx", rxw(b_rx), 32'h3C);
    chk("t3_mosi_ones", mosi1_cnt - b_mosi1, 0);
    chk("t3_rises", rise_cnt - b_rise, 8);

    // RX full for a two-word burst: overflow pulses, same waveform.
    snap();
    rx_full = 1'b1;
    push(8'h5A); push(8'hC3);
    wait_idle("t4_idle");
    rx_full = 1'b0;
    chk("t4_ovf", ovf_cnt - b_ovf, 2);
    chk("t4_wen", wen_cnt - b_wen, 0);
    chk("t4_rises", rise_cnt - b_rise, 16);
    chk("t4_cs_low_cycles", cslow_cnt - b_cslow, 70);

    // i_en dropped during bit 2 of word 1 with two words queued.
    snap();
    push(8'h11); push(8'h22);
    wait_rises(3, "t5_rises");
    step();
    i_en = 1'b0;
    wait_idle("t5_idle1");
    repeat (5) step();
    chk("t5_ren_first", ren_cnt - b_ren, 1);
    chk("t5_wen_first", wen_cnt - b_wen, 1);
    chk("t5_rx0", rxw(b_rx), 32'h11);
    chk("t5_idle_busy", o_busy, 0);
    i_en = 1'b1;
    wait_idle("t5_idle2");
    chk("t5_ren_total", ren_cnt - b_ren, 2);
    chk("t5_rx1", rxw(b_rx + 1), 32'h22);

    // One-cycle reset pulse during bit 3.
    snap();
    push(8'h33); push(8'h44);
    wait_rises(4, "t6_rises");
    step();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("t6_cs_n", o_cs_n, 1);
    chk("t6_sclk", o_sclk, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_rx_wen", rx_wen, 0);
    step();
    wait_idle("t6_idle");
    chk("t6_ren", ren_cnt - b_ren, 2);
    chk("t6_wen", wen_cnt - b_wen, 1);
    chk("t6_rx", rxw(b_rx), 32'h44);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
